truth_table_engine: RTL and testbench
=====================================

TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 Parameter IN_W, default 4, SHALL set the input-vector width; the table holds 2^IN_W rows.
REQ-002 Parameter OUT_N, default 10, SHALL set the number of output functions (bits per row).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 tbl_we  input  1  SHALL request a table-row write this cycle.
REQ-006 tbl_addr  input  IN_W  SHALL be the table row to write.
REQ-007 tbl_wdata  input  OUT_N  SHALL be the row contents; bit k is function Fk.
REQ-008 in_valid / in_ready  input / output  1 / 1  SHALL be the lookup-request handshake.
REQ-009 in_data  input  IN_W  SHALL be the lookup input vector; bit IN_W-1 is the MSB.
REQ-010 out_valid / out_ready  output / input  1 / 1  SHALL be the result handshake.
REQ-011 out_data  output  OUT_N  SHALL be the table row for the accepted vector.
REQ-012 out_idx  output  IN_W  SHALL echo the vector that produced out_data.
REQ-013 sweep_start  input  1  SHALL request an automatic full-table sweep.
REQ-014 busy  output  1  SHALL be high when the FSM is not IDLE.
REQ-015 sweep_done  output  1  SHALL pulse high for exactly one cycle at sweep completion.

Function
REQ-016 Lookup SHALL be accepted on in_valid & in_ready; out_valid, out_data and out_idx SHALL register on that edge (latency 1 cycle).
REQ-017 in_ready SHALL equal (!out_valid | out_ready) & (state == IDLE).
REQ-018 out_data, out_idx and out_valid SHALL hold stable while out_valid & !out_ready.
REQ-019 A table write SHALL take effect at the clock edge; a lookup of the same row on that edge SHALL return the old contents.
REQ-020 tbl_we SHALL be ignored, with the table unchanged, while the FSM is not IDLE.
REQ-021 The FSM SHALL have the states IDLE, SWEEP and DRAIN.
REQ-022 IDLE -> SWEEP SHALL occur on sweep_start in IDLE, with the index counter cleared to 0; sweep_start outside IDLE SHALL be ignored.
REQ-023 In SWEEP, whenever the output stage is free (!out_valid | out_ready), the engine SHALL load the row for the counter value and increment the counter by 1.
REQ-024 When the counter value 2^IN_W-1 is issued, the FSM SHALL go SWEEP -> DRAIN without the counter wrapping.
REQ-025 DRAIN -> IDLE SHALL occur when out_valid & out_ready is seen with out_idx = 2^IN_W-1; sweep_done SHALL pulse on that same edge.
REQ-026 A sweep SHALL emit exactly 2^IN_W results, in ascending order, with no gaps or duplicates, under arbitrary out_ready backpressure.
REQ-027 in_valid during SWEEP or DRAIN SHALL stall, with in_ready = 0 and no request lost.

Reset
REQ-028 When rst_n is low, the FSM SHALL be IDLE, and the counter and all table rows SHALL be 0.
REQ-029 When rst_n is low, out_valid, out_data, out_idx, sweep_done and busy SHALL be 0, and in_ready SHALL be 1.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately, with no sweep_done pulse.

Configuration
REQ-031 When TTE_PARITY_EN is defined, the engine SHALL add the output out_par (1 bit), registered with out_data, equal to the XOR of out_data bits.
REQ-032 When TTE_PARITY_EN is defined, out_par SHALL reset to 0.
REQ-033 When TTE_PARITY_EN is undefined, out_par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Scenario: write row 3 = 10'h2A5, then look up in_data = 3 -> after 1 cycle, out_valid = 1, out_data = 10'h2A5 and out_idx = 3.
REQ-035 Scenario: on one edge, write row 5 = 10'h3FF and look up 5 with row 5 previously 10'h001 -> result 10'h001; the next lookup of 5 returns 10'h3FF.
REQ-036 Scenario: rows i = i*3 (mod 1024) with sweep_start pulsed and out_ready held at 1 -> 16 results with idx 0..15 on consecutive cycles, and sweep_done pulses once alongside idx 15.
REQ-037 Scenario: a sweep with out_ready toggling in a 1-0-0 pattern -> all 16 rows appear in order, and each held result stays stable while stalled.
REQ-038 Scenario: during a sweep, assert tbl_we on row 0 = 10'h155 and in_valid -> the write is ignored, in_ready = 0, and the lookup completes after IDLE.
REQ-039 Scenario: assert rst_n = 0 at sweep idx 7 -> out_valid = 0 and busy = 0 at once, no sweep_done pulse, and every row reads 0 afterwards.

Source files
------------

// File: rtl/truth_table_engine.sv
// truth_table_engine
//   Programmable truth table: 2^IN_W rows of OUT_N output functions.
//   Rows are written through the tbl_* port. Lookups go through a
//   valid/ready handshake with a one-cycle registered result. A sweep
//   mode streams every row, in ascending index order, through the same
//   output stage.
//
//   Parameters
//     IN_W   input-vector width (table depth 2^IN_W)
//     OUT_N  output functions per row (row width)
//
//   Ports
//     clk, rst_n               clock, async active-low reset
//     tbl_we/addr/wdata        row write (ignored while busy)
//     in_valid/in_ready/in_data    lookup request
//     out_valid/out_ready          result handshake
//     out_data/out_idx             row contents and the index that produced it
//     sweep_start              start a full-table sweep (IDLE only)
//     busy                     FSM not IDLE
//     sweep_done               one-cycle pulse on the final sweep handshake
//     out_par                  XOR of out_data (only with TTE_PARITY_EN)
//
//   Build option
//     TTE_PARITY_EN  adds the registered parity output out_par.

// One table row: a resettable register with its own write enable.
module tte_row #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] row_o
);
  logic [W-1:0] row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    row_q <= '0;
    else if (we_i) row_q <= wdata_i;
  end

  assign row_o = row_q;
endmodule

module truth_table_engine #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tbl_we,
  input  logic [IN_W-1:0]  tbl_addr,
  input  logic [OUT_N-1:0] tbl_wdata,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] out_data,
  output logic [IN_W-1:0]  out_idx,
  input  logic             sweep_start,
  output logic             busy,
`ifdef TTE_PARITY_EN
  output logic             out_par,
`endif
  output logic             sweep_done
);
  localparam int ROWS = 1 << IN_W;
  localparam logic [IN_W-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;

  typedef struct packed {
    logic             vld;
    logic [OUT_N-1:0] data;
    logic [IN_W-1:0]  idx;
  } rsp_t;

  state_e          state_q, state_d;
  logic [IN_W-1:0] cnt_q, cnt_d;
  rsp_t            rsp_q, rsp_d;

  logic [ROWS-1:0][OUT_N-1:0] tbl;
  logic [ROWS-1:0]            row_we;

  logic            stage_free;
  logic            ld;
  logic [IN_W-1:0] ld_idx;

  // Table writes are only honoured in IDLE so a sweep sees a frozen table.
  always_comb begin
    row_we = '0;
    if (tbl_we && (state_q == IDLE)) row_we[tbl_addr] = 1'b1;
  end

  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_row
      tte_row #(.W(OUT_N)) u_row (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (row_we[r]),
        .wdata_i (tbl_wdata),
        .row_o   (tbl[r])
      );
    end
  endgenerate

  assign stage_free = !rsp_q.vld || out_ready;
  assign in_ready   = stage_free && (state_q == IDLE);
  assign busy       = (state_q != IDLE);

  // Combinational so the pulse coincides with the cycle in which the last
  // sweep result is presented and accepted.
  assign sweep_done = (state_q == DRAIN) && rsp_q.vld && out_ready &&
                      (rsp_q.idx == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    ld      = 1'b0;
    ld_idx  = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          ld     = 1'b1;
          ld_idx = in_data;
        end
        if (sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (stage_free) begin
          ld     = 1'b1;
          ld_idx = cnt_q;
          // Stop at the last row rather than wrapping the counter.
          if (cnt_q == LAST) state_d = DRAIN;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (rsp_q.vld && out_ready && (rsp_q.idx == LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reads use the pre-edge table, so a same-edge write is not visible.
    if (ld) begin
      rsp_d.vld  = 1'b1;
      rsp_d.data = tbl[ld_idx];
      rsp_d.idx  = ld_idx;
    end else if (out_ready) begin
      rsp_d.vld  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef TTE_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^rsp_d.data;
  end
  assign out_par = par_q;
`endif

  assign out_valid = rsp_q.vld;
  assign out_data  = rsp_q.data;
  assign out_idx   = rsp_q.idx;
endmodule

// File: tb/tb_truth_table_engine.sv
// Directed-vector bench for truth_table_engine (IN_W=4, OUT_N=10).
module tb_truth_table_engine;
  localparam int IN_W  = 4;
  localparam int OUT_N = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             tbl_we = 1'b0;
  logic [IN_W-1:0]  tbl_addr = '0;
  logic [OUT_N-1:0] tbl_wdata = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_N-1:0] out_data;
  logic [IN_W-1:0]  out_idx;
  logic             sweep_start = 1'b0;
  logic             busy;
  logic             sweep_done;
`ifdef TTE_PARITY_EN
  logic             out_par;
`endif

  int vecs = 0;
  int errs = 0;

  truth_table_engine #(.IN_W(IN_W), .OUT_N(OUT_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .sweep_start(sweep_start),
    .busy       (busy),
`ifdef TTE_PARITY_EN
    .out_par    (out_par),
`endif
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IN_W-1:0] a, input logic [OUT_N-1:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick(); tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vecs++; if (out_data !== '0) begin errs++; $display("FAIL reset_out_data got %h want 000", out_data); end
    vecs++; if (out_idx !== '0) begin errs++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy); end
    vecs++; if (sweep_done !== 1'b0) begin errs++; $display("FAIL reset_sweep_done got %0b want 0", sweep_done); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    rst_n = 1'b1;
    tick();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_write_lookup();
    logic [OUT_N-1:0] v;
    v = 10'h2A5;
    wr(4'd3, v);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'd3;
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL lookup_valid got %0b want 1", out_valid); end
    vecs++; if (out_data !== v) begin errs++; $display("FAIL lookup_data got %h want %h", out_data, v); end
    vecs++; if (out_idx !== 4'd3) begin errs++; $display("FAIL lookup_idx got %0d want 3", out_idx); end
`ifdef TTE_PARITY_EN
    vecs++; if (out_par !== ^v) begin errs++; $display("FAIL lookup_par got %0b want %0b", out_par, ^v); end
`endif
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lookup_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_same_edge();
    wr(4'd5, 10'h001);
    tbl_we = 1'b1; tbl_addr = 4'd5; tbl_wdata = 10'h3FF;
    in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b1;
    tick();
    tbl_we = 1'b0;
    vecs++; if (out_data !== 10'h001) begin errs++; $display("FAIL same_edge_old got %h want 001", out_data); end
    tick();
    in_valid = 1'b0;
    vecs++; if (out_data !== 10'h3FF) begin errs++; $display("FAIL same_edge_new got %h want 3ff", out_data); end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd3;
    tick();
    in_data = 4'd5;  // second request must wait, not be lost
    vecs++; if (out_valid !== 1'b1 || out_data !== 10'h2A5 || out_idx !== 4'd3) begin
      errs++; $display("FAIL hold_first got v=%0b d=%h i=%0d want v=1 d=2a5 i=3", out_valid, out_data, out_idx);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++; if (out_valid !== 1'b1 || out_data !== 10'h2A5 || out_idx !== 4'd3 || in_ready !== 1'b0) begin
        errs++; $display("FAIL hold_stable got v=%0b d=%h i=%0d rdy=%0b want v=1 d=2a5 i=3 rdy=0", out_valid, out_data, out_idx, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL hold_release_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || out_idx !== 4'd5 || out_data !== 10'h3FF) begin
      errs++; $display("FAIL hold_b2b got v=%0b d=%h i=%0d want v=1 d=3ff i=5", out_valid, out_data, out_idx);
    end
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL hold_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_sweep();
    int dones;
    logic [OUT_N-1:0] e;
    dones = 0;
    for (int i = 0; i < 16; i++) wr(IN_W'(i), OUT_N'(i * 3));
    out_ready = 1'b1; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    vecs++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errs++; $display("FAIL sweep_enter got busy=%0b rdy=%0b want busy=1 rdy=0", busy, in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      e = OUT_N'(i * 3);
      vecs++; if (out_valid !== 1'b1 || out_idx !== IN_W'(i) || out_data !== e) begin
        errs++; $display("FAIL sweep_row got v=%0b i=%0d d=%h want v=1 i=%0d d=%h", out_valid, out_idx, out_data, i, e);
      end
      vecs++; if (sweep_done !== (i == 15)) begin
        errs++; $display("FAIL sweep_done_timing at idx %0d got %0b want %0b", i, sweep_done, (i == 15));
      end
      if (sweep_done) dones++;
    end
    tick();
    vecs++; if (busy !== 1'b0 || out_valid !== 1'b0 || sweep_done !== 1'b0) begin
      errs++; $display("FAIL sweep_exit got busy=%0b v=%0b done=%0b want 0 0 0", busy, out_valid, sweep_done);
    end
    vecs++; if (dones !== 1) begin errs++; $display("FAIL sweep_done_count got %0d want 1", dones); end
  endtask

  task automatic test_backpressure();
    int exp_i, cyc, dones;
    logic stall;
    logic [OUT_N+IN_W:0] held;
    exp_i = 0; cyc = 0; dones = 0; stall = 1'b0; held = '0;
    out_ready = 1'b0; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    while (exp_i < 16 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      #1;
      if (stall) begin
        vecs++; if ({out_valid, out_data, out_idx} !== held) begin
          errs++; $display("FAIL bp_stable got %h want %h", {out_valid, out_data, out_idx}, held);
        end
      end
      if (out_valid && out_ready) begin
        vecs++; if (out_idx !== IN_W'(exp_i) || out_data !== OUT_N'(exp_i * 3)) begin
          errs++; $display("FAIL bp_order got i=%0d d=%h want i=%0d d=%h", out_idx, out_data, exp_i, OUT_N'(exp_i * 3));
        end
        vecs++; if (sweep_done !== (exp_i == 15)) begin
          errs++; $display("FAIL bp_done at %0d got %0b want %0b", exp_i, sweep_done, (exp_i == 15));
        end
        exp_i++;
      end
      if (sweep_done) dones++;
      stall = out_valid && !out_ready;
      held  = {out_valid, out_data, out_idx};
      cyc++;
      tick();
    end
    out_ready = 1'b1;
    vecs++; if (exp_i != 16) begin errs++; $display("FAIL bp_timeout got %0d results want 16", exp_i); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_idle got busy=%0b want 0", busy); end
    vecs++; if (dones != 1) begin errs++; $display("FAIL bp_done_count got %0d want 1", dones); end
  endtask

  task automatic test_busy_ignore();
    int cyc, leaks;
    cyc = 0; leaks = 0;
    out_ready = 1'b1; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick(); tick();
    tbl_we = 1'b1; tbl_addr = 4'd0; tbl_wdata = 10'h155;
    in_valid = 1'b1; in_data = 4'd0;
    #1;
    vecs++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL busy_block got rdy=%0b busy=%0b want rdy=0 busy=1", in_ready, busy);
    end
    tick(); tick();
    tbl_we = 1'b0;
    while (!in_ready && cyc < 50) begin
      if (busy && in_ready) leaks++;
      tick();
      cyc++;
    end
    vecs++; if (cyc >= 50) begin errs++; $display("FAIL busy_timeout got %0d cycles want <50", cyc); end
    vecs++; if (leaks != 0) begin errs++; $display("FAIL busy_ready_leak got %0d want 0", leaks); end
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_data !== 10'h000) begin
      errs++; $display("FAIL busy_ignored_write got v=%0b i=%0d d=%h want v=1 i=0 d=000", out_valid, out_idx, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, dones;
    cyc = 0; dones = 0;
    out_ready = 1'b1; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    while (!(out_valid && out_idx == 4'd7) && cyc < 50) begin
      tick();
      cyc++;
    end
    vecs++; if (cyc >= 50) begin errs++; $display("FAIL rst_sweep_timeout got %0d cycles want <50", cyc); end
    rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL rst_abort got v=%0b busy=%0b done=%0b rdy=%0b want 0 0 0 1", out_valid, busy, sweep_done, in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (sweep_done) dones++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (sweep_done) dones++;
    end
    vecs++; if (dones != 0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_no_resume got done_pulses=%0d busy=%0b want 0 0", dones, busy);
    end
    // Back-to-back lookups of every row; all must read as cleared.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = IN_W'(i);
      tick();
      vecs++; if (out_valid !== 1'b1 || out_idx !== IN_W'(i) || out_data !== '0) begin
        errs++; $display("FAIL rst_row_clear got v=%0b i=%0d d=%h want v=1 i=%0d d=000", out_valid, out_idx, out_data, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_lookup();
    test_same_edge();
    test_hold();
    test_sweep();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
